bp_me_prefetch_issue_scheduler: RTL and testbench

//  Shares the single memory-command issue slot between demand misses and prefetch candidates from the

---
 rtl/bp_me_prefetch_pkg.sv | 29 ++
 rtl/bp_me_prefetch_queue.sv | 102 ++++++++++
 rtl/bp_me_prefetch_issue_scheduler.sv | 165 ++++++++++++++++
 tb/tb_bp_me_prefetch_issue_scheduler.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_me_prefetch_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : bp_me_prefetch_pkg                                             |
// | Purpose : Shared types and helpers for the prefetch issue scheduler:     |
// |           queue entry struct, load-select encoding, block-offset width.  |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package bp_me_prefetch_pkg;

   localparam int daddr_width_gp = 64;

   typedef struct packed {
      logic                      v;
      logic [daddr_width_gp-1:0] addr;
   } bp_pf_entry_s;

   typedef enum logic [1:0] {
      e_sel_none     = 2'd0,
      e_sel_demand   = 2'd1,
      e_sel_prefetch = 2'd2
   } bp_pf_sel_e;

   // Number of byte-offset bits inside one cache block.
   function automatic int bp_block_offset_width(input int block_width);
      return $clog2(block_width / 8);
   endfunction

endpackage
`default_nettype wire

// File: rtl/bp_me_prefetch_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : bp_me_prefetch_queue                                           |
// | Purpose : Circular FIFO of prefetch candidates with per-entry valid.     |
// |           A block-address match port reports duplicates, and an         |
// |           invalidate port clears entries whose block matches.           |
// |           Invalidated entries still occupy a slot until they reach the   |
// |           head, where they are discarded without being presented.       |
// | Ports   : clk_i, reset_n_i (sync, active low), flush_i (sync clear)      |
// |           push_v_i/push_addr_i  enqueue (caller guarantees not full)     |
// |           pop_i                 consume a valid head                     |
// |           head_v_o/head_addr_o  head entry (valid only if live)          |
// |           match_blk_i/match_o   duplicate lookup                         |
// |           inv_v_i/inv_blk_i     invalidate-on-match                      |
// |           count_o               occupied slots                           |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module bp_me_prefetch_queue
   import bp_me_prefetch_pkg::*;
#(
   parameter int  daddr_width_p = 64,
   parameter int  block_width_p = 512,
   parameter int  els_p         = 4,
   localparam int blk_w_lp      = daddr_width_p - bp_block_offset_width(block_width_p),
   localparam int cnt_w_lp      = $clog2(els_p + 1)
)(
   input  logic                     clk_i,
   input  logic                     reset_n_i,
   input  logic                     flush_i,
   input  logic                     push_v_i,
   input  logic [daddr_width_p-1:0] push_addr_i,
   input  logic                     pop_i,
   output logic                     head_v_o,
   output logic [daddr_width_p-1:0] head_addr_o,
   input  logic [blk_w_lp-1:0]      match_blk_i,
   output logic                     match_o,
   input  logic                     inv_v_i,
   input  logic [blk_w_lp-1:0]      inv_blk_i,
   output logic [cnt_w_lp-1:0]      count_o
);

   localparam int ptr_w_lp = $clog2(els_p);
   localparam int off_lp   = daddr_width_p - blk_w_lp;

   logic [daddr_width_p-1:0] addr_r [els_p];
   logic [els_p-1:0]         v_r;
   logic [els_p-1:0]         hit;
   logic [els_p-1:0]         inv_hit;
   logic [ptr_w_lp-1:0]      rptr_r;
   logic [ptr_w_lp-1:0]      wptr_r;
   logic                     nonempty;
   logic                     deq;

   for (genvar i = 0; i < els_p; i++) begin : g_entry
      assign hit[i]     = v_r[i] & (addr_r[i][daddr_width_p-1:off_lp] == match_blk_i);
      assign inv_hit[i] = v_r[i] & (addr_r[i][daddr_width_p-1:off_lp] == inv_blk_i);
   end

   assign match_o     = |hit;
   assign nonempty    = (count_o != '0);
   assign head_v_o    = nonempty & v_r[rptr_r];
   assign head_addr_o = addr_r[rptr_r];
   // A dead head is dropped on its own so it never blocks live entries behind it.
   assign deq         = nonempty & (pop_i | ~v_r[rptr_r]);

   always_ff @(posedge clk_i) begin
      if (push_v_i) begin
         addr_r[wptr_r] <= push_addr_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i || flush_i) begin
         v_r     <= '0;
         rptr_r  <= '0;
         wptr_r  <= '0;
         count_o <= '0;
      end else begin
         // Later bit writes override the bulk invalidate; the push slot is
         // always empty, and the popped slot is never invalidated and pushed
         // in the same cycle.
         if (inv_v_i) begin
            v_r <= v_r & ~inv_hit;
         end
         if (deq) begin
            v_r[rptr_r] <= 1'b0;
            rptr_r      <= rptr_r + ptr_w_lp'(1);
         end
         if (push_v_i) begin
            v_r[wptr_r] <= 1'b1;
            wptr_r      <= wptr_r + ptr_w_lp'(1);
         end
         case ({push_v_i, deq})
            2'b10:   count_o <= count_o + cnt_w_lp'(1);
            2'b01:   count_o <= count_o - cnt_w_lp'(1);
            default: count_o <= count_o;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/bp_me_prefetch_issue_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : bp_me_prefetch_issue_scheduler                                 |
// | Purpose : Shares one memory-command slot between demand misses and       |
// |           queued prefetch candidates. Demand has priority except when    |
// |           the starvation bound is reached; prefetches are throttled by   |
// |           an outstanding limit; duplicate candidates are dropped.        |
// | Ports   : clk_i, reset_n_i (sync, active low)                            |
// |           demand_addr_i/demand_v_i/demand_ready_and_o  demand input      |
// |           pf_addr_i/pf_v_i/pf_ready_and_o, pf_enable_i  candidate input  |
// |           mem_addr_o/mem_prefetch_o/mem_v_o/mem_ready_and_i  command out |
// |           pf_done_i       one prefetch completion per pulse              |
// |           outstanding_o   prefetches in flight                           |
// |           queue_count_o   queued candidates                              |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module bp_me_prefetch_issue_scheduler
   import bp_me_prefetch_pkg::*;
#(
   parameter int  daddr_width_p     = 64,
   parameter int  block_width_p     = 512,
   parameter int  queue_els_p       = 4,
   parameter int  max_outstanding_p = 4,
   parameter int  starve_limit_p    = 8,
   localparam int out_w_lp          = $clog2(max_outstanding_p + 1),
   localparam int cnt_w_lp          = $clog2(queue_els_p + 1)
)(
   input  logic                     clk_i,
   input  logic                     reset_n_i,
   input  logic [daddr_width_p-1:0] demand_addr_i,
   input  logic                     demand_v_i,
   output logic                     demand_ready_and_o,
   input  logic [daddr_width_p-1:0] pf_addr_i,
   input  logic                     pf_v_i,
   output logic                     pf_ready_and_o,
   input  logic                     pf_enable_i,
   output logic [daddr_width_p-1:0] mem_addr_o,
   output logic                     mem_prefetch_o,
   output logic                     mem_v_o,
   input  logic                     mem_ready_and_i,
   input  logic                     pf_done_i,
   output logic [out_w_lp-1:0]      outstanding_o,
   output logic [cnt_w_lp-1:0]      queue_count_o
);

   localparam int off_lp      = bp_block_offset_width(block_width_p);
   localparam int starve_w_lp = $clog2(starve_limit_p + 1);

   logic                     load_ok;
   logic                     pending_pf;
   logic [out_w_lp:0]        inflight;
   logic                     pf_eligible;
   logic                     force_pf;
   logic                     demand_fire;
   logic                     pf_dup;
   logic                     pf_push;
   logic                     head_v;
   logic [daddr_width_p-1:0] head_addr;
   logic                     q_match;
   logic                     issue_pf;
   logic                     done_dec;
   logic [starve_w_lp-1:0]   starve_cnt;
   bp_pf_sel_e               sel;

   assign load_ok    = ~mem_v_o | mem_ready_and_i;
   // A prefetch sitting in the output register is counted against the limit
   // before it issues; otherwise back-to-back loads could overshoot it.
   assign pending_pf = mem_v_o & mem_prefetch_o;
   assign inflight   = (out_w_lp+1)'(outstanding_o) + (out_w_lp+1)'(pending_pf);
   // Eligibility looks at a live head so a superseded entry never steals a slot.
   assign pf_eligible = pf_enable_i & head_v
                      & (inflight < (out_w_lp+1)'(max_outstanding_p));
   assign force_pf    = pf_eligible & (starve_cnt == starve_w_lp'(starve_limit_p));

   assign demand_ready_and_o = load_ok & reset_n_i & ~force_pf;
   assign demand_fire        = demand_v_i & demand_ready_and_o;

   assign pf_ready_and_o = pf_enable_i & reset_n_i & (queue_count_o < cnt_w_lp'(queue_els_p));
   assign pf_dup  = q_match
                  | (mem_v_o & (mem_addr_o[daddr_width_p-1:off_lp] == pf_addr_i[daddr_width_p-1:off_lp]));
   assign pf_push = pf_v_i & pf_ready_and_o & ~pf_dup;

   always_comb begin
      sel = e_sel_none;
      if (load_ok) begin
         if (demand_v_i && !force_pf) begin
            sel = e_sel_demand;
         end else if (pf_eligible) begin
            sel = e_sel_prefetch;
         end
      end
   end

   bp_me_prefetch_queue #(
      .daddr_width_p (daddr_width_p),
      .block_width_p (block_width_p),
      .els_p         (queue_els_p)
   ) queue (
      .clk_i       (clk_i),
      .reset_n_i   (reset_n_i),
      .flush_i     (~pf_enable_i),
      .push_v_i    (pf_push),
      .push_addr_i (pf_addr_i),
      .pop_i       (sel == e_sel_prefetch),
      .head_v_o    (head_v),
      .head_addr_o (head_addr),
      .match_blk_i (pf_addr_i[daddr_width_p-1:off_lp]),
      .match_o     (q_match),
      .inv_v_i     (demand_fire),
      .inv_blk_i   (demand_addr_i[daddr_width_p-1:off_lp]),
      .count_o     (queue_count_o)
   );

   // Output register: reloads whenever it is empty or draining this cycle.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         mem_v_o        <= 1'b0;
         mem_addr_o     <= '0;
         mem_prefetch_o <= 1'b0;
      end else if (load_ok) begin
         case (sel)
            e_sel_demand: begin
               mem_v_o        <= 1'b1;
               mem_addr_o     <= demand_addr_i;
               mem_prefetch_o <= 1'b0;
            end
            e_sel_prefetch: begin
               mem_v_o        <= 1'b1;
               mem_addr_o     <= head_addr;
               mem_prefetch_o <= 1'b1;
            end
            default: begin
               mem_v_o        <= 1'b0;
               mem_addr_o     <= '0;
               mem_prefetch_o <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i || !pf_eligible) begin
         starve_cnt <= '0;
      end else if (sel == e_sel_prefetch) begin
         starve_cnt <= '0;
      end else if (sel == e_sel_demand && starve_cnt != starve_w_lp'(starve_limit_p)) begin
         starve_cnt <= starve_cnt + starve_w_lp'(1);
      end
   end

   assign issue_pf = mem_v_o & mem_ready_and_i & mem_prefetch_o;
   assign done_dec = pf_done_i & (outstanding_o != '0);

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         outstanding_o <= '0;
      end else if (issue_pf && !done_dec) begin
         outstanding_o <= outstanding_o + out_w_lp'(1);
      end else if (done_dec && !issue_pf) begin
         outstanding_o <= outstanding_o - out_w_lp'(1);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_bp_me_prefetch_issue_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_bp_me_prefetch_issue_scheduler                              |
// | Purpose : Directed bench with a scoreboard of expected memory commands   |
// |           and a monitor that pops it on every command handshake.         |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_bp_me_prefetch_issue_scheduler;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [63:0] demand_addr;
   logic        demand_v;
   logic        demand_ready;
   logic [63:0] pf_addr;
   logic        pf_v;
   logic        pf_ready;
   logic        pf_enable;
   logic [63:0] mem_addr;
   logic        mem_prefetch;
   logic        mem_v;
   logic        mem_ready;
   logic        pf_done;
   logic [2:0]  outstanding;
   logic [2:0]  queue_count;

   typedef struct {
      logic [63:0] addr;
      logic        pf;
   } exp_t;

   exp_t exp_q[$];
   int   vectors     = 0;
   int   miscompares = 0;

   bp_me_prefetch_issue_scheduler #(
      .daddr_width_p     (64),
      .block_width_p     (512),
      .queue_els_p       (4),
      .max_outstanding_p (4),
      .starve_limit_p    (8)
   ) dut (
      .clk_i              (clk),
      .reset_n_i          (reset_n),
      .demand_addr_i      (demand_addr),
      .demand_v_i         (demand_v),
      .demand_ready_and_o (demand_ready),
      .pf_addr_i          (pf_addr),
      .pf_v_i             (pf_v),
      .pf_ready_and_o     (pf_ready),
      .pf_enable_i        (pf_enable),
      .mem_addr_o         (mem_addr),
      .mem_prefetch_o     (mem_prefetch),
      .mem_v_o            (mem_v),
      .mem_ready_and_i    (mem_ready),
      .pf_done_i          (pf_done),
      .outstanding_o      (outstanding),
      .queue_count_o      (queue_count)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   task automatic expect_issue(input logic [63:0] a, input logic pf);
      exp_t e;
      e.addr = a;
      e.pf   = pf;
      exp_q.push_back(e);
   endtask

   // Handshake inputs change only just after posedge, so the negedge view
   // is exactly what the next posedge will accept.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (mem_v && mem_ready) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL issue_unexpected: got addr 0x%0h pf %0b, required no command", mem_addr, mem_prefetch);
         end else begin
            e = exp_q.pop_front();
            if (mem_addr !== e.addr || mem_prefetch !== e.pf) begin
               miscompares++;
               $display("FAIL issue: got addr 0x%0h pf %0b, required addr 0x%0h pf %0b",
                        mem_addr, mem_prefetch, e.addr, e.pf);
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got no finish, required finish before 200000");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int n;
      reset_n = 1'b0; demand_addr = '0; demand_v = 1'b0; pf_addr = '0; pf_v = 1'b0;
      pf_enable = 1'b1; mem_ready = 1'b0; pf_done = 1'b0;
      tick(2);
      check("reset_mem_v", mem_v, 0);
      check("reset_outstanding", outstanding, 0);
      check("reset_queue_count", queue_count, 0);
      check("reset_demand_ready", demand_ready, 0);
      check("reset_pf_ready", pf_ready, 0);
      reset_n = 1'b1;
      #1;
      check("post_reset_pf_ready", pf_ready, 1);
      tick(1);

      // Demand-only back-to-back
      mem_ready = 1'b1; demand_v = 1'b1; demand_addr = 64'h1000;
      check("d_ready", demand_ready, 1);
      expect_issue(64'h1000, 1'b0);
      tick(1);
      check("d_cycle1_v", mem_v, 1);
      check("d_cycle1_addr", mem_addr, 64'h1000);
      demand_addr = 64'h2040;
      expect_issue(64'h2040, 1'b0);
      tick(1);
      check("d_cycle2_addr", mem_addr, 64'h2040);
      check("d_cycle2_pf", mem_prefetch, 0);
      demand_v = 1'b0;
      tick(1);
      check("d_idle_v", mem_v, 0);

      // Queue fill while the output register is held by a demand
      mem_ready = 1'b0; demand_v = 1'b1; demand_addr = 64'h9000;
      expect_issue(64'h9000, 1'b0);
      tick(1);
      demand_v = 1'b0;
      for (int i = 0; i < 5; i++) begin
         pf_v = 1'b1; pf_addr = 64'hA000 + 64'(i) * 64'h40;
         check($sformatf("fill_pf_ready_%0d", i), pf_ready, (i < 4) ? 1 : 0);
         tick(1);
      end
      pf_v = 1'b0;
      check("fill_count", queue_count, 4);
      for (int i = 0; i < 4; i++) expect_issue(64'hA000 + 64'(i) * 64'h40, 1'b1);
      mem_ready = 1'b1;
      tick(6);
      check("drain_outstanding", outstanding, 4);
      check("drain_count", queue_count, 0);

      // Throttle: nothing issues at the limit; one completion frees one slot
      pf_v = 1'b1; pf_addr = 64'hB000; tick(1);
      pf_addr = 64'hB040; tick(1);
      pf_v = 1'b0;
      tick(2);
      check("throttle_count", queue_count, 2);
      check("throttle_mem_v", mem_v, 0);
      pf_done = 1'b1; tick(1); pf_done = 1'b0;
      expect_issue(64'hB000, 1'b1);
      tick(4);
      check("throttle_one_more_out", outstanding, 4);
      check("throttle_one_more_count", queue_count, 1);
      pf_enable = 1'b0;
      tick(1);
      check("flush_count", queue_count, 0);
      pf_done = 1'b1; tick(5); pf_done = 1'b0;
      check("done_no_underflow", outstanding, 0);
      pf_enable = 1'b1;
      tick(1);

      // Duplicate drop against queue and output register; demand supersedes
      mem_ready = 1'b0; demand_v = 1'b1; demand_addr = 64'h5000;
      expect_issue(64'h5000, 1'b0);
      tick(1);
      demand_v = 1'b0;
      pf_v = 1'b1; pf_addr = 64'h1000; tick(1);
      pf_addr = 64'h1010;
      check("dup_pf_ready", pf_ready, 1);
      tick(1);
      pf_addr = 64'h5020; tick(1);
      pf_v = 1'b0;
      check("dup_count", queue_count, 1);
      mem_ready = 1'b1; demand_v = 1'b1; demand_addr = 64'h1030;
      expect_issue(64'h1030, 1'b0);
      tick(1);
      demand_v = 1'b0;
      tick(3);
      check("supersede_count", queue_count, 0);
      check("supersede_mem_v", mem_v, 0);

      // Starvation bound with continuous demand
      n = 0;
      for (int i = 0; i < 12; i++) begin
         demand_v = 1'b1; demand_addr = 64'hD000 + 64'(n) * 64'h40;
         pf_v = (i == 0); pf_addr = 64'hC000;
         check($sformatf("starve_ready_%0d", i), demand_ready, (i == 9) ? 0 : 1);
         if (i == 9) expect_issue(64'hC000, 1'b1);
         else begin
            expect_issue(demand_addr, 1'b0);
            n++;
         end
         tick(1);
      end
      demand_v = 1'b0; pf_v = 1'b0;
      tick(3);
      check("starve_outstanding", outstanding, 1);

      // Reset mid-operation discards held and queued commands
      mem_ready = 1'b0; demand_v = 1'b1; demand_addr = 64'hE000;
      tick(1);
      demand_v = 1'b0;
      for (int i = 0; i < 3; i++) begin
         pf_v = 1'b1; pf_addr = 64'hE100 + 64'(i) * 64'h40;
         tick(1);
      end
      pf_v = 1'b0;
      check("prereset_count", queue_count, 3);
      check("prereset_mem_v", mem_v, 1);
      reset_n = 1'b0;
      tick(1);
      reset_n = 1'b1;
      check("midreset_mem_v", mem_v, 0);
      check("midreset_count", queue_count, 0);
      check("midreset_outstanding", outstanding, 0);
      mem_ready = 1'b1;
      tick(3);
      check("postreset_idle", mem_v, 0);

      check("scoreboard_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
